// File: rtl/task_dispatcher_pkg.sv
// Shared definitions for task_dispatcher: fence codes, FSM states and
// control-word field positions.
package task_dispatcher_pkg;

  localparam logic [1:0] FENCE_NO  = 2'd0;
  localparam logic [1:0] FENCE_ACQ = 2'd1;
  localparam logic [1:0] FENCE_REL = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CTRL,
    ST_ISSUE,
    ST_SETTLE,
    ST_WAIT,
    ST_DONE
  } state_t;

  // Control word, LSB upward: IF_NUM, FENCE, HALT, ACTIVE, R0_VECT, R0.
  function automatic int fence_lsb(input int ifn_w);
    return ifn_w;
  endfunction

  function automatic int halt_lsb(input int ifn_w);
    return ifn_w + 2;
  endfunction

  function automatic int active_lsb(input int ifn_w);
    return ifn_w + 3;
  endfunction

  function automatic int r0v_lsb(input int ifn_w, input int num_cores);
    return ifn_w + 3 + num_cores;
  endfunction

  function automatic int r0_lsb(input int ifn_w, input int num_cores);
    return ifn_w + 3 + 2 * num_cores;
  endfunction

  function automatic int ctrl_w(input int ifn_w, input int num_cores, input int reg_w);
    return ifn_w + 3 + 2 * num_cores + num_cores * reg_w;
  endfunction

endpackage

// File: rtl/task_dispatcher_mem.sv
// Task memory for task_dispatcher: synchronous write, asynchronous read.
module task_dispatcher_mem #(
  parameter int WORD_W   = 64,
  parameter int TM_DEPTH = 256,
  parameter int AW       = 8
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [TM_DEPTH];

  // NOTE: the array has no reset on purpose; the program must survive a reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/task_dispatcher.sv
// Dispatches task frames from a loaded program to per-task core sets with fence
// ordering. Define TD_PERF_CNT_EN to add the stall_cnt performance counter.
module task_dispatcher
  import task_dispatcher_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int REG_W     = 8,
  parameter int WORD_W    = 64,
  parameter int TM_DEPTH  = 256,
  parameter int IFN_W     = 8,
  localparam int AW       = $clog2(TM_DEPTH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       tm_wr_en,
  input  logic [AW-1:0]              tm_wr_addr,
  input  logic [WORD_W-1:0]          tm_wr_data,
  input  logic                       go,
  output logic                       busy,
  output logic                       done,
  input  logic [NUM_CORES-1:0]       Ready,
  output logic [NUM_CORES-1:0]       Start,
  output logic [WORD_W-1:0]          Insn_Data,
  output logic [NUM_CORES-1:0]       Init_R0_Vect,
  output logic [NUM_CORES*REG_W-1:0] Init_R0
`ifdef TD_PERF_CNT_EN
  ,
  output logic [31:0]                stall_cnt
`endif
);

  localparam int FENCE_LSB  = fence_lsb(IFN_W);
  localparam int HALT_LSB   = halt_lsb(IFN_W);
  localparam int ACTIVE_LSB = active_lsb(IFN_W);
  localparam int R0V_LSB    = r0v_lsb(IFN_W, NUM_CORES);
  localparam int R0_LSB     = r0_lsb(IFN_W, NUM_CORES);

  state_t                 state;
  logic [AW-1:0]          ptr;
  logic [NUM_CORES-1:0]   active;
  logic [IFN_W-1:0]       frames_left;
  logic                   rel_pending;
  logic [WORD_W-1:0]      rd_word;

  task_dispatcher_mem #(
    .WORD_W   (WORD_W),
    .TM_DEPTH (TM_DEPTH),
    .AW       (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (tm_wr_en & ~busy),
    .wr_addr (tm_wr_addr),
    .wr_data (tm_wr_data),
    .rd_addr (ptr),
    .rd_data (rd_word)
  );

  logic [IFN_W-1:0]           c_ifn;
  logic [1:0]                 c_fence;
  logic                       c_halt;
  logic [NUM_CORES-1:0]       c_active;
  logic [NUM_CORES-1:0]       c_r0v;
  logic [NUM_CORES*REG_W-1:0] c_r0;

  assign c_ifn    = rd_word[IFN_W-1:0];
  assign c_fence  = rd_word[FENCE_LSB +: 2];
  assign c_halt   = rd_word[HALT_LSB];
  assign c_active = rd_word[ACTIVE_LSB +: NUM_CORES];
  assign c_r0v    = rd_word[R0V_LSB +: NUM_CORES];
  assign c_r0     = rd_word[R0_LSB +: NUM_CORES*REG_W];

  // A pending release or an acquire-type fence (code 3 included) drains every core.
  logic need_all, fence_ok, frames_ready;
  assign need_all     = rel_pending || (c_fence != FENCE_NO && c_fence != FENCE_REL);
  assign fence_ok     = need_all ? (&Ready) : ((Ready & c_active) == c_active);
  assign frames_ready = (Ready & active) == active;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      ptr          <= '0;
      active       <= '0;
      frames_left  <= '0;
      rel_pending  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      Start        <= '0;
      Insn_Data    <= '0;
      Init_R0_Vect <= '0;
      Init_R0      <= '0;
    end else begin
      // NOTE: Start defaults low every cycle so it can only ever be a single-cycle strobe.
      Start <= '0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (go) begin
            state       <= ST_CTRL;
            ptr         <= '0;
            busy        <= 1'b1;
            done        <= 1'b0;
            rel_pending <= 1'b0;
          end
        end
        ST_CTRL: begin
          if (c_halt) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (fence_ok) begin
            active       <= c_active;
            frames_left  <= c_ifn;
            Init_R0_Vect <= c_r0v;
            Init_R0      <= c_r0;
            rel_pending  <= (c_fence == FENCE_REL);
            ptr          <= ptr + AW'(1);
            state        <= (c_ifn == '0) ? ST_CTRL : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          Start       <= active;
          Insn_Data   <= rd_word;
          ptr         <= ptr + AW'(1);
          frames_left <= frames_left - IFN_W'(1);
          state       <= ST_SETTLE;
        end
        ST_SETTLE: state <= (frames_left == '0) ? ST_CTRL : ST_WAIT;
        ST_WAIT: begin
          if (frames_ready) state <= ST_ISSUE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef TD_PERF_CNT_EN
  logic stall;
  assign stall = (state == ST_CTRL && !c_halt && !fence_ok) ||
                 (state == ST_WAIT && !frames_ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if ((state == ST_IDLE || state == ST_DONE) && go) begin
      stall_cnt <= '0;
    end else if (stall && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_task_dispatcher.sv
// Randomised and directed bench for task_dispatcher; a program-walking model
// predicts the ordered frame stream and the fence each first frame must honour.
module tb_task_dispatcher;

  localparam int N        = 4;
  localparam int REG_W    = 8;
  localparam int WORD_W   = 64;
  localparam int TM_DEPTH = 32;
  localparam int IFN_W    = 8;
  localparam int AW       = 5;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                tm_wr_en = 1'b0;
  logic [AW-1:0]       tm_wr_addr = '0;
  logic [WORD_W-1:0]   tm_wr_data = '0;
  logic                go = 1'b0;
  logic [N-1:0]        Ready = '1;
  wire                 busy, done;
  wire [N-1:0]         Start, Init_R0_Vect;
  wire [WORD_W-1:0]    Insn_Data;
  wire [N*REG_W-1:0]   Init_R0;
`ifdef TD_PERF_CNT_EN
  wire [31:0]          stall_cnt;
`endif

  always #5 clk = ~clk;

  task_dispatcher #(
    .NUM_CORES (N),
    .REG_W     (REG_W),
    .WORD_W    (WORD_W),
    .TM_DEPTH  (TM_DEPTH),
    .IFN_W     (IFN_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .tm_wr_en     (tm_wr_en),
    .tm_wr_addr   (tm_wr_addr),
    .tm_wr_data   (tm_wr_data),
    .go           (go),
    .busy         (busy),
    .done         (done),
    .Ready        (Ready),
    .Start        (Start),
    .Insn_Data    (Insn_Data),
    .Init_R0_Vect (Init_R0_Vect),
    .Init_R0      (Init_R0)
`ifdef TD_PERF_CNT_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [N-1:0]       act;
    logic [WORD_W-1:0]  data;
    logic [N-1:0]       r0v;
    logic [N*REG_W-1:0] r0;
    bit                 first;
    bit                 need_all;
  } exp_t;

  logic [WORD_W-1:0] img [TM_DEPTH];
  exp_t              exp_q[$];
  int                start_step_q[$];
  logic [N-1:0]      start_ready_q[$];
  int                busy_cnt [N];
  int                force_cnt [N];
  int                dur [N];
  bit                rand_dur = 0;
  bit                prev_start = 0;
  logic [N-1:0]      rdy_e1 = '1;

  function automatic logic [63:0] ctrl_word(input int ifn, input int fence, input int halt,
                                            input logic [3:0] act, input logic [3:0] r0v,
                                            input logic [31:0] r0);
    return 64'(ifn) | (64'(fence) << 8) | (64'(halt) << 10) | (64'(act) << 11) |
           (64'(r0v) << 15) | (64'(r0) << 19);
  endfunction

  function automatic void fill_halt();
    for (int a = 0; a < TM_DEPTH; a++) img[a] = ctrl_word(0, 0, 1, 4'h0, 4'h0, 32'h0);
  endfunction

  task automatic load_program();
    for (int a = 0; a < TM_DEPTH; a++) begin
      tm_wr_en   = 1'b1;
      tm_wr_addr = AW'(a);
      tm_wr_data = img[a];
      @(posedge clk); #1;
    end
    tm_wr_en = 1'b0;
  endtask

  task automatic cores_reset(input int d);
    for (int j = 0; j < N; j++) begin
      busy_cnt[j]  = 0;
      force_cnt[j] = 0;
      dur[j]       = d;
    end
    Ready    = '1;
    rand_dur = 0;
  endtask

  // Walk the program as the host would read it: tasks in order, wrapping addresses.
  function automatic void build_expected();
    int p = 0;
    bit rel = 0;
    logic [WORD_W-1:0] w;
    int ifn, f;
    bit na;
    exp_q.delete();
    for (int t = 0; t < 4 * TM_DEPTH; t++) begin
      w = img[p];
      if (w[10]) break;
      ifn = int'(w[7:0]);
      f   = int'(w[9:8]);
      na  = rel || f == 1 || f == 3;
      rel = (f == 2);
      p   = (p + 1) % TM_DEPTH;
      for (int i = 0; i < ifn; i++) begin
        exp_q.push_back('{w[14:11], img[p], w[18:15], w[50:19], i == 0, na});
        p = (p + 1) % TM_DEPTH;
      end
    end
  endfunction

  // One clock: observe Start after the edge, then let the modelled cores react.
  task automatic step(input int idx);
    logic [N-1:0] rb;
    exp_t e;
    rb = Ready;
    @(posedge clk); #1;
    if (Start != '0) begin
      start_step_q.push_back(idx);
      start_ready_q.push_back(rdy_e1);
      check("start_gap", 64'(prev_start), 64'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_start", 64'(Start), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("start_vec", 64'(Start), 64'(e.act));
        check("insn_data", Insn_Data, e.data);
        check("init_vect", 64'(Init_R0_Vect), 64'(e.r0v));
        check("init_r0", 64'(Init_R0), 64'(e.r0));
        if (e.first && e.need_all) check("fence_all", 64'(rdy_e1), 64'hF);
        else check("fence_active", 64'(rdy_e1 & e.act), 64'(e.act));
      end
    end
    prev_start = (Start != '0);
    rdy_e1 = rb;
    for (int j = 0; j < N; j++) begin
      if (busy_cnt[j] > 0) busy_cnt[j]--;
      if (force_cnt[j] > 0) force_cnt[j]--;
      if (Start[j]) busy_cnt[j] = rand_dur ? int'($urandom_range(1, 6)) : dur[j];
      Ready[j] = (busy_cnt[j] == 0) && (force_cnt[j] == 0);
    end
  endtask

  task automatic start_run();
    build_expected();
    start_step_q.delete();
    start_ready_q.delete();
    prev_start = 0;
    go = 1'b1;
    step(0);
    go = 1'b0;
  endtask

  task automatic run_program(input string name, input int budget);
    start_run();
    for (int i = 1; i <= budget && !done; i++) step(i);
    check({name, "_done"}, 64'(done), 64'd1);
    check({name, "_busy"}, 64'(busy), 64'd0);
    check({name, "_left"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic gen_random();
    int p;
    int ifn;
    fill_halt();
    p = 0;
    while (p < TM_DEPTH - 6) begin
      ifn = int'($urandom_range(0, 3));
      img[p] = ctrl_word(ifn, int'($urandom_range(0, 3)), 0, 4'($urandom_range(1, 15)),
                         4'($urandom), 32'($urandom));
      p++;
      for (int i = 0; i < ifn; i++) begin
        img[p] = {$urandom, $urandom};
        p++;
      end
    end
    img[p] = ctrl_word(0, 0, 1, 4'h0, 4'h0, 32'h0);
  endtask

  initial begin
    fill_halt();
    cores_reset(1);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_start", 64'(Start), 64'd0);
    check("rst_insn", Insn_Data, 64'd0);
    check("rst_vect", 64'(Init_R0_Vect), 64'd0);
    check("rst_r0", 64'(Init_R0), 64'd0);
`ifdef TD_PERF_CNT_EN
    check("rst_stall", 64'(stall_cnt), 64'd0);
`endif
    reset = 1'b1;
    @(posedge clk); #1;

    // Two-frame task on cores 0,1 with R0 init, then halt.
    fill_halt();
    img[0] = ctrl_word(2, 0, 0, 4'b0011, 4'b0001, 32'h5A);
    img[1] = 64'h1111_2222_3333_4444;
    img[2] = 64'hAAAA_BBBB_CCCC_DDDD;
    load_program();
    cores_reset(1);
    run_program("basic", 200);
    check("basic_nstart", 64'(start_step_q.size()), 64'd2);
    if (start_step_q.size() >= 2) begin
      check("basic_latency", 64'(start_step_q[0]), 64'd2);
      check("basic_spacing", 64'(start_step_q[1] - start_step_q[0]), 64'd3);
    end
    check("basic_r0_slice0", 64'(Init_R0[7:0]), 64'h5A);

    // REL task on 0011 then NO task on 1100: B waits for all cores.
    fill_halt();
    img[0] = ctrl_word(1, 2, 0, 4'b0011, 4'b0000, 32'h0);
    img[1] = 64'h0000_0000_0000_A0A0;
    img[2] = ctrl_word(1, 0, 0, 4'b1100, 4'b0000, 32'h0);
    img[3] = 64'h0000_0000_0000_B0B0;
    load_program();
    cores_reset(1);
    dur[0] = 10;
    dur[1] = 10;
    run_program("rel", 300);
    check("rel_nstart", 64'(start_step_q.size()), 64'd2);
    if (start_step_q.size() >= 2) begin
      check("rel_held", 64'(start_step_q[1] - start_step_q[0] > 10), 64'd1);
      check("rel_all_ready", 64'(start_ready_q[1]), 64'hF);
    end

    // Same pair with NO fence: B overlaps cores 0,1 still busy.
    img[0] = ctrl_word(1, 0, 0, 4'b0011, 4'b0000, 32'h0);
    load_program();
    cores_reset(1);
    dur[0] = 10;
    dur[1] = 10;
    run_program("overlap", 300);
    check("overlap_nstart", 64'(start_step_q.size()), 64'd2);
    if (start_step_q.size() >= 2) begin
      check("overlap_busy", 64'(start_ready_q[1][1:0]), 64'd0);
      check("overlap_spacing", 64'(start_step_q[1] - start_step_q[0]), 64'd3);
    end

    // Last task straddles TM_DEPTH-1 -> 0; word 0 goes out as a frame.
    fill_halt();
    img[0] = ctrl_word(1, 0, 0, 4'b0001, 4'b0000, 32'h0);
    for (int a = 2; a < TM_DEPTH - 2; a++) img[a] = ctrl_word(0, 0, 0, 4'h0, 4'h0, 32'h0);
    img[TM_DEPTH-2] = ctrl_word(2, 0, 0, 4'b0010, 4'b0000, 32'h0);
    img[TM_DEPTH-1] = 64'hFEED_0000_0000_001F;
    load_program();
    cores_reset(1);
    run_program("wrap", 400);
    check("wrap_nstart", 64'(start_step_q.size()), 64'd3);

    // Reset mid-WAIT, with a dropped write attempted while busy, then rerun.
    fill_halt();
    img[0] = ctrl_word(2, 0, 0, 4'b0001, 4'b0001, 32'h77);
    img[1] = 64'h0123_4567_89AB_CDEF;
    img[2] = 64'hFEDC_BA98_7654_3210;
    load_program();
    cores_reset(1);
    dur[0] = 10;
    start_run();
    for (int i = 1; i <= 4; i++) step(i);
    tm_wr_en   = 1'b1;
    tm_wr_addr = AW'(1);
    tm_wr_data = ~img[1];
    step(5);
    tm_wr_en = 1'b0;
    check("mid_busy", 64'(busy), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_start", 64'(Start), 64'd0);
    check("midrst_insn", Insn_Data, 64'd0);
    check("midrst_vect", 64'(Init_R0_Vect), 64'd0);
    check("midrst_r0", 64'(Init_R0), 64'd0);
`ifdef TD_PERF_CNT_EN
    check("midrst_stall", 64'(stall_cnt), 64'd0);
`endif
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    cores_reset(1);
    @(posedge clk); #1;
    run_program("rerun", 200);
    check("rerun_nstart", 64'(start_step_q.size()), 64'd2);

`ifdef TD_PERF_CNT_EN
    // ACQ task held off by Ready=0000 for seven CTRL cycles.
    fill_halt();
    img[0] = ctrl_word(1, 1, 0, 4'b0001, 4'b0000, 32'h0);
    img[1] = 64'h5555_5555_5555_5555;
    load_program();
    cores_reset(1);
    for (int j = 0; j < N; j++) force_cnt[j] = 8;
    Ready = '0;
    run_program("stall", 200);
    check("stall_cnt", 64'(stall_cnt), 64'd7);
`endif

    // Random programs with random core busy times.
    for (int r = 0; r < 4; r++) begin
      gen_random();
      load_program();
      cores_reset(1);
      rand_dur = 1;
      run_program("rand", 2000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
